// File: rtl/hdr_insert_pkg.sv
// Shared types and helpers for the header-insert arbiter.
// State encoding plus a constant-safe ceil(log2) helper.
package hdr_insert_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/hdr_insert_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches upward from ptr+1 and wraps; the pointer lives in the caller.
module rr_arbiter
  import hdr_insert_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int GRANT_WD = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [GRANT_WD-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [GRANT_WD-1:0] idx
);

  logic                found;
  logic [GRANT_WD-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = GRANT_WD'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/hdr_insert_arbiter.sv
// Arbitrates N header+payload streams onto one inserter port.
// A winner owns the output for one header beat then a full payload.
module hdr_insert_arbiter
  import hdr_insert_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int GRANT_WD     = clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_hdr_tvalid,
  output logic [NUM_REQ-1:0]              req_hdr_tready,
  input  logic [NUM_REQ*DATA_WD-1:0]      req_hdr_tdata,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_hdr_tkeep,
  input  logic [NUM_REQ-1:0]              req_dat_tvalid,
  input  logic [NUM_REQ-1:0]              req_dat_tlast,
  output logic [NUM_REQ-1:0]              req_dat_tready,
  input  logic [NUM_REQ*DATA_WD-1:0]      req_dat_tdata,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_dat_tkeep,
  output logic                            m_hdr_tvalid,
  output logic [DATA_WD-1:0]              m_hdr_tdata,
  output logic [DATA_BYTE_WD-1:0]         m_hdr_tkeep,
  input  logic                            m_hdr_tready,
  output logic                            m_dat_tvalid,
  output logic [DATA_WD-1:0]              m_dat_tdata,
  output logic [DATA_BYTE_WD-1:0]         m_dat_tkeep,
  output logic                            m_dat_tlast,
  input  logic                            m_dat_tready,
  output logic [GRANT_WD-1:0]             grant_id,
  output logic                            busy,
  output logic [15:0]                     pkt_cnt
);

  state_t              state_q, state_d;
  logic [GRANT_WD-1:0] grant_q, grant_d;
  logic [GRANT_WD-1:0] ptr_q, ptr_d;
  logic [15:0]         pkt_cnt_q;
  logic                cnt_inc;
  logic [NUM_REQ-1:0]  win_oh;
  logic [GRANT_WD-1:0] win_idx;

  logic [DATA_WD-1:0]      hdr_data [NUM_REQ];
  logic [DATA_BYTE_WD-1:0] hdr_keep [NUM_REQ];
  logic [DATA_WD-1:0]      dat_data [NUM_REQ];
  logic [DATA_BYTE_WD-1:0] dat_keep [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign hdr_data[g] =
      req_hdr_tdata[g*DATA_WD +: DATA_WD];
    assign hdr_keep[g] =
      req_hdr_tkeep[g*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign dat_data[g] =
      req_dat_tdata[g*DATA_WD +: DATA_WD];
    assign dat_keep[g] =
      req_dat_tkeep[g*DATA_BYTE_WD +: DATA_BYTE_WD];
  end

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .GRANT_WD (GRANT_WD)
  ) u_rr (
    .req (req_hdr_tvalid),
    .ptr (ptr_q),
    .gnt (win_oh),
    .idx (win_idx)
  );

  // Data paths follow the registered owner; only valid/ready are gated.
  assign m_hdr_tdata = hdr_data[grant_q];
  assign m_hdr_tkeep = hdr_keep[grant_q];
  assign m_dat_tdata = dat_data[grant_q];
  assign m_dat_tkeep = dat_keep[grant_q];
  assign m_dat_tlast = req_dat_tlast[grant_q];

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    ptr_d          = ptr_q;
    cnt_inc        = 1'b0;
    m_hdr_tvalid   = 1'b0;
    m_dat_tvalid   = 1'b0;
    req_hdr_tready = '0;
    req_dat_tready = '0;
    case (state_q)
      IDLE: begin
        if (|win_oh) begin
          state_d = HDR;
          grant_d = win_idx;
          ptr_d   = win_idx;
        end
      end
      HDR: begin
        m_hdr_tvalid            = req_hdr_tvalid[grant_q];
        req_hdr_tready[grant_q] = m_hdr_tready;
        if (m_hdr_tvalid && m_hdr_tready) state_d = DATA;
      end
      DATA: begin
        m_dat_tvalid            = req_dat_tvalid[grant_q];
        req_dat_tready[grant_q] = m_dat_tready;
        if (m_dat_tvalid && m_dat_tready && m_dat_tlast) begin
          state_d = IDLE;
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= GRANT_WD'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_cnt_q <= '0;
    else if (cnt_inc) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
  assign pkt_cnt  = pkt_cnt_q;

endmodule
